bit_scan_seq: RTL and testbench

- Multi-cycle, parametrised bit-analysis unit for the datapath utility library.
- Latches a WIDTH-bit operand and scans it STEP bits per cycle.
- Produces one of four results, selected by mode:
  - population count
  - count leading zeros (CLZ)
  - count trailing zeros (CTZ)
  - parity
- Uses a start/busy/done handshake so the iterative result can sit behind a stall in the processor.

---
 rtl/bit_scan_seq.sv | 119 +++++++++++
 tb/tb_bit_scan_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_scan_seq.sv
// Iterative bit analyser that scans a latched operand STEP bits per cycle.
// It computes popcount, CLZ, CTZ or parity and reports the result with a start/busy/done handshake.
module bit_scan_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    result,
  output logic             b
);

  if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_params
    $error("bit_scan_seq: WIDTH must be >= 2 and divisible by STEP");
  end

  localparam int unsigned N = WIDTH / STEP;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef enum logic [1:0] {OP_POP, OP_CLZ, OP_CTZ, OP_PAR} op_t;

  state_t           state, state_nx;
  op_t              op;
  logic [WIDTH-1:0] opnd;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    idx;

  logic [STEP-1:0]  chunk;
  logic [CW-1:0]    ones, lo_pos, hi_dist;
  logic [CW-1:0]    final_val;
  logic             hit, last, fin, flag;

  // The operand register is shifted each cycle, so the current chunk always
  // sits at the LSB end (popcount/parity/CTZ) or the MSB end (CLZ).
  always_comb begin
    chunk   = (op == OP_CLZ) ? opnd[WIDTH-1 -: STEP] : opnd[STEP-1:0];
    ones    = '0;
    lo_pos  = '0;
    hi_dist = '0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (chunk[i]) ones = ones + CW'(1);
      if (chunk[i]) hi_dist = CW'(STEP - 1 - i);
      if (chunk[STEP-1-i]) lo_pos = CW'(STEP - 1 - i);
    end
  end

  always_comb begin
    hit  = (op == OP_CLZ || op == OP_CTZ) && (|chunk);
    last = (idx == CW'(N - 1));
    fin  = hit || last;
    case (op)
      OP_CLZ:  final_val = hit ? acc + hi_dist : acc + CW'(STEP);
      OP_CTZ:  final_val = hit ? acc + lo_pos  : acc + CW'(STEP);
      default: final_val = acc + ones;
    endcase
    if (op == OP_CLZ || op == OP_CTZ) flag = (final_val == CW'(WIDTH));
    else                              flag = final_val[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN:    if (fin)   state_nx = DONE;
      DONE:    state_nx = start ? SCAN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SCAN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op     <= OP_POP;
      opnd   <= '0;
      acc    <= '0;
      idx    <= '0;
      result <= '0;
      b      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op   <= op_t'(mode);
            opnd <= a;
            acc  <= '0;
            idx  <= '0;
          end
        end
        SCAN: begin
          if (fin) begin
            result <= final_val;
            b      <= flag;
          end else begin
            acc  <= final_val;
            idx  <= idx + CW'(1);
            opnd <= (op == OP_CLZ) ? (opnd << STEP) : (opnd >> STEP);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_scan_seq.sv
// Scoreboard bench for bit_scan_seq: a bit-level reference model queues expectations at issue time,
// and a monitor checks them whenever done is asserted.
module tb_bit_scan_seq;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;
  localparam int CW    = 6;
  localparam int N     = WIDTH / STEP;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] a = '0;
  logic             busy, done, b;
  logic [CW-1:0]    result;

  bit_scan_seq #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .a(a),
    .busy(busy), .done(done), .result(result), .b(b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned res;
    bit          flag;
    int unsigned lat;
    int unsigned e0;
    logic [1:0]  m;
    logic [31:0] v;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned last_done_cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned got, input int unsigned want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: count bits / find extreme set bits directly, derive latency from chunk index.
  function automatic exp_t model(input logic [1:0] m, input logic [31:0] v);
    exp_t e;
    int unsigned cnt = 0;
    int          lo = -1, hi = -1;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        cnt++;
        if (lo < 0) lo = i;
        hi = i;
      end
    end
    e.m = m; e.v = v; e.e0 = 0;
    case (m)
      2'd0, 2'd3: begin e.res = cnt; e.flag = cnt[0]; e.lat = N; end
      2'd2: begin
        e.res = (v == 0) ? WIDTH : lo;
        e.lat = (v == 0) ? N : (lo / STEP) + 1;
        e.flag = (v == 0);
      end
      default: begin
        e.res = (v == 0) ? WIDTH : (WIDTH - 1 - hi);
        e.lat = (v == 0) ? N : ((WIDTH - 1 - hi) / STEP) + 1;
        e.flag = (v == 0);
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("result m=%0d a=%h", e.m, e.v), result, e.res);
        chk($sformatf("flag m=%0d a=%h", e.m, e.v), b, e.flag);
        chk($sformatf("latency m=%0d a=%h", e.m, e.v), cyc - e.e0, e.lat);
        chk("busy_at_done", busy, 0);
      end
      last_done_cyc = cyc;
    end
  end

  task automatic issue(input logic [1:0] m, input logic [31:0] v, output int unsigned e0);
    int unsigned n = 0;
    exp_t e;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("issue_timeout", 1, 0);
    start = 1'b1; mode = m; a = v;
    @(posedge clk);
    #1;
    e0 = cyc;
    e = model(m, v);
    e.e0 = e0;
    sb.push_back(e);
    start = 1'b0;
    mode = 2'($urandom);
    a = $urandom;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int unsigned e0;
    logic [31:0] v;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_b", b, 0);
    end

    issue(2'd0, 32'd31, e0);
    drain();
    issue(2'd0, 32'd288, e0);
    issue(2'd3, 32'd288, e0);
    chk("back_to_back_no_bubble", e0, last_done_cyc + 1);
    issue(2'd1, 32'd2, e0);
    issue(2'd1, 32'd288, e0);
    issue(2'd2, 32'd2, e0);
    issue(2'd2, 32'd288, e0);
    issue(2'd1, 32'd0, e0);
    issue(2'd2, 32'd0, e0);
    issue(2'd1, 32'h8000_0000, e0);
    issue(2'd2, 32'h8000_0000, e0);
    drain();

    // start while busy must be dropped: only one done may follow.
    issue(2'd0, 32'h0F0F_0F0F, e0);
    @(negedge clk); start = 1'b1; mode = 2'd2; a = 32'd1;
    @(negedge clk); start = 1'b0;
    drain();
    repeat (12) @(negedge clk);

    // Asynchronous reset mid-scan abandons the operation.
    issue(2'd0, 32'hFFFF_0000, e0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_b", b, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    chk("midrst_hold_done", done, 0);
    reset = 1'b1;
    issue(2'd0, 32'd31, e0);
    drain();

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 7))
        0:       v = 32'd0;
        1, 2:    v = 32'd1 << $urandom_range(0, 31);
        3, 4:    v = $urandom & $urandom & $urandom;
        default: v = $urandom;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(2'($urandom), v, e0);
    end
    drain();
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
